// File: rtl/ni_pkg.sv
// Shared NI slave definitions: FSM state encoding, latency bound, and the
// byte-address to register-index decode helper.
package ni_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WACK  = 2'd1,
    RWAIT = 2'd2,
    RRESP = 2'd3
  } ni_slv_state_t;

  localparam int NI_MAX_READ_LATENCY = 8;

  typedef struct packed {
    logic        hit;
    logic [31:0] index;
  } ni_idx_t;

  // The offset is reduced to addr_width bits so an address below the base
  // wraps to a large value and lands outside the register range.
  function automatic ni_idx_t ni_word_index(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned addr_width,
    input int unsigned stride,
    input int unsigned num_regs
  );
    logic [31:0] mask;
    logic [31:0] offset;
    ni_idx_t     res;
    mask      = (addr_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << addr_width) - 32'd1);
    offset    = (addr - base) & mask;
    res.index = offset / 32'(stride);
    res.hit   = ((offset % 32'(stride)) == 32'd0) && (res.index < 32'(num_regs));
    return res;
  endfunction

endpackage

// File: rtl/ni_slave_addr_decode.sv
// Combinational byte-address decode into a register index and hit flag.
module ni_slave_addr_decode
  import ni_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int BASE_ADDR  = 0,
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  o_hit,
  output logic [IDX_W-1:0]      o_index
);

  ni_idx_t w_res;
  logic    w_unused;

  assign w_res    = ni_word_index(32'(i_addr), 32'(BASE_ADDR), ADDR_WIDTH,
                                  DATA_WIDTH / 8, NUM_REGS);
  assign o_hit    = w_res.hit;
  assign o_index  = w_res.index[IDX_W-1:0];
  assign w_unused = ^w_res.index[31:IDX_W];

endmodule

// File: rtl/ni_slave_regfile.sv
// NI slave responder terminating write/read transactions into a register bank;
// read-only slots return live hw_in status.
//
// state | meaning
// IDLE  | accepts wen/ren
// WACK  | drives wack; launches a captured simultaneous read on exit
// RWAIT | read latency countdown
// RRESP | drives rvalid and rdata
module ni_slave_regfile
  import ni_pkg::*;
#(
  parameter int                     DATA_WIDTH   = 32,
  parameter int                     ADDR_WIDTH   = 16,
  parameter int                     NUM_REGS     = 16,
  parameter int                     BASE_ADDR    = 0,
  parameter logic [NUM_REGS-1:0]    RO_MASK      = '0,
  parameter int                     READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0]  RESET_VAL    = '0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           wen,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic                           wack,
  input  logic                           ren,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           rvalid,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_strobe_o,
  output logic                           err_o
);

  localparam int       IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

  ni_slv_state_t         r_state, w_state_nxt;
  logic [2:0]            r_cnt, w_cnt_nxt;
  logic                  r_pend;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic                  r_rd_hit;
  logic [IDX_W-1:0]      r_rd_idx;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic [NUM_REGS-1:0]   r_wr_strobe;

  logic                  w_wr_go, w_wr_ok, w_rd_start, w_drop;
  logic                  w_wdec_hit, w_rdec_hit, w_rs_hit;
  logic [IDX_W-1:0]      w_wdec_idx, w_rdec_idx, w_rs_idx;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_hw   [NUM_REGS];

  ni_slave_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)
  ) u_wdec (
    .i_addr (waddr),
    .o_hit  (w_wdec_hit),
    .o_index(w_wdec_idx)
  );

  // In WACK the only read that may start is the one captured alongside the write.
  assign w_rd_addr = (r_state == WACK) ? r_pend_addr : raddr;

  ni_slave_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)
  ) u_rdec (
    .i_addr (w_rd_addr),
    .o_hit  (w_rdec_hit),
    .o_index(w_rdec_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_go     = 1'b0;
    w_rd_start  = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (wen) begin
          w_wr_go     = 1'b1;
          w_state_nxt = WACK;
        end else if (ren) begin
          w_rd_start = 1'b1;
        end
      end
      WACK: begin
        w_drop = wen | ren;
        if (r_pend) w_rd_start = 1'b1;
        else        w_state_nxt = IDLE;
      end
      RWAIT: begin
        w_drop    = wen | ren;
        w_cnt_nxt = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_state_nxt = RRESP;
      end
      RRESP: begin
        w_drop      = wen | ren;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_rd_start) begin
      if (READ_LATENCY <= 1) begin
        w_state_nxt = RRESP;
      end else begin
        w_state_nxt = RWAIT;
        w_cnt_nxt   = LAT_LOAD;
      end
    end
  end

  assign w_wr_ok  = w_wr_go & w_wdec_hit & ~RO_MASK[w_wdec_idx];
  assign w_rs_hit = w_rd_start ? w_rdec_hit : r_rd_hit;
  assign w_rs_idx = w_rd_start ? w_rdec_idx : r_rd_idx;
  assign w_rd_val = !w_rs_hit           ? '0 :
                    RO_MASK[w_rs_idx]   ? w_hw[w_rs_idx] : w_regs[w_rs_idx];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_rd_hit    <= 1'b0;
      r_rd_idx    <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_wr_strobe <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_wr_go) begin
        r_pend      <= ren;
        r_pend_addr <= raddr;
      end else if (w_rd_start) begin
        r_pend <= 1'b0;
      end
      if (w_rd_start) begin
        r_rd_hit <= w_rdec_hit;
        r_rd_idx <= w_rdec_idx;
      end
      // RO status is sampled at the edge that raises rvalid.
      r_rdata     <= (w_state_nxt == RRESP) ? w_rd_val : '0;
      r_err       <= (w_wr_go & ~w_wr_ok) | ((w_state_nxt == RRESP) & ~w_rs_hit) | w_drop;
      r_wr_strobe <= w_wr_ok ? (NUM_REGS'(1) << w_wdec_idx) : '0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign w_hw[i] = hw_in[i*DATA_WIDTH +: DATA_WIDTH];
    if (RO_MASK[i]) begin : g_ro
      assign w_regs[i] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] r_val;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                r_val <= RESET_VAL;
        else if (w_wr_ok && w_wdec_idx == IDX_W'(i)) r_val <= wdata;
      end
      assign w_regs[i] = r_val;
    end
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = w_regs[i];
  end

  assign wack        = (r_state == WACK);
  assign rvalid      = (r_state == RRESP);
  assign rdata       = r_rdata;
  assign err_o       = r_err;
  assign wr_strobe_o = r_wr_strobe;

endmodule

// File: tb/tb_ni_slave_regfile.sv
// Directed bench: three responders (read latency 1, 3, 4) share one stimulus
// stream; each step checks the instance whose latency it targets.
module tb_ni_slave_regfile;

  logic         clk = 1'b0;
  logic         rstn;
  logic         wen, ren;
  logic [15:0]  waddr, raddr;
  logic [31:0]  wdata;
  logic [511:0] hw_in;

  logic         wack1, rvalid1, err1, wack3, rvalid3, err3, wack4, rvalid4, err4;
  logic [31:0]  rdata1, rdata3, rdata4;
  logic [511:0] regs1, regs3, regs4;
  logic [15:0]  strobe1, strobe3, strobe4;

  int errors = 0;
  int checks = 0;
  logic seen;

  always #5 clk = ~clk;

  ni_slave_regfile #(.RO_MASK(16'h8000), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .rstn(rstn), .wen(wen), .waddr(waddr), .wdata(wdata), .wack(wack1),
    .ren(ren), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .hw_in(hw_in),
    .regs_o(regs1), .wr_strobe_o(strobe1), .err_o(err1));

  ni_slave_regfile #(.RO_MASK(16'h8000), .READ_LATENCY(3)) u_l3 (
    .clk(clk), .rstn(rstn), .wen(wen), .waddr(waddr), .wdata(wdata), .wack(wack3),
    .ren(ren), .raddr(raddr), .rdata(rdata3), .rvalid(rvalid3), .hw_in(hw_in),
    .regs_o(regs3), .wr_strobe_o(strobe3), .err_o(err3));

  ni_slave_regfile #(.RO_MASK(16'h8000), .READ_LATENCY(4)) u_l4 (
    .clk(clk), .rstn(rstn), .wen(wen), .waddr(waddr), .wdata(wdata), .wack(wack4),
    .ren(ren), .raddr(raddr), .rdata(rdata4), .rvalid(rvalid4), .hw_in(hw_in),
    .regs_o(regs4), .wr_strobe_o(strobe4), .err_o(err4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; hw_in = '0;
    hw_in[15*32 +: 32] = 32'h1234_5678;
    #3 rstn = 1'b0;
    #4;
    chk("rst_wack",   64'(wack1),   64'd0);
    chk("rst_rvalid", 64'(rvalid1), 64'd0);
    chk("rst_rdata",  64'(rdata1),  64'd0);
    chk("rst_err",    64'(err1),    64'd0);
    chk("rst_strobe", 64'(strobe1), 64'd0);
    chk("rst_regs",   64'(|regs1),  64'd0);
    idle(2);
    rstn = 1'b1;
    idle(2);

    // 1: write reg 2 then read it back at latency 1
    wen = 1'b1; waddr = 16'h0008; wdata = 32'hCAFE_F00D;
    tick();
    wen = 1'b0;
    chk("t1_wack",   64'(wack1),   64'd1);
    chk("t1_strobe", 64'(strobe1), 64'h4);
    chk("t1_err",    64'(err1),    64'd0);
    chk("t1_reg2",   64'(regs1[2*32 +: 32]), 64'hCAFE_F00D);
    tick();
    chk("t1_wack_drop",   64'(wack1),   64'd0);
    chk("t1_strobe_drop", 64'(strobe1), 64'd0);
    ren = 1'b1; raddr = 16'h0008;
    tick();
    ren = 1'b0;
    chk("t1_rvalid", 64'(rvalid1), 64'd1);
    chk("t1_rdata",  64'(rdata1),  64'hCAFE_F00D);
    tick();
    chk("t1_rvalid_drop", 64'(rvalid1), 64'd0);
    chk("t1_rdata_drop",  64'(rdata1),  64'd0);
    idle(6);

    // 2: read-only register 15 returns hw_in; writes to it are refused
    ren = 1'b1; raddr = 16'h003C;
    tick();
    ren = 1'b0;
    chk("t2_rvalid", 64'(rvalid1), 64'd1);
    chk("t2_rdata",  64'(rdata1),  64'h1234_5678);
    tick();
    wen = 1'b1; waddr = 16'h003C; wdata = 32'hFFFF_FFFF;
    tick();
    wen = 1'b0;
    chk("t2_wack",   64'(wack1),   64'd1);
    chk("t2_err",    64'(err1),    64'd1);
    chk("t2_strobe", 64'(strobe1), 64'd0);
    tick();
    chk("t2_err_drop", 64'(err1), 64'd0);
    ren = 1'b1; raddr = 16'h003C;
    tick();
    ren = 1'b0;
    chk("t2_rdata_again", 64'(rdata1), 64'h1234_5678);
    chk("t2_regs_ro_zero", 64'(regs1[15*32 +: 32]), 64'd0);
    idle(6);

    // 3: simultaneous write and read of reg 1 at latency 3
    wen = 1'b1; ren = 1'b1; waddr = 16'h0004; raddr = 16'h0004; wdata = 32'hA5A5_A5A5;
    tick();
    wen = 1'b0; ren = 1'b0;
    chk("t3_wack",     64'(wack3),   64'd1);
    chk("t3_rvalid_1", 64'(rvalid3), 64'd0);
    tick();
    chk("t3_wack_drop", 64'(wack3),   64'd0);
    chk("t3_rvalid_2",  64'(rvalid3), 64'd0);
    tick();
    chk("t3_rvalid_3", 64'(rvalid3), 64'd0);
    tick();
    chk("t3_rvalid_4", 64'(rvalid3), 64'd1);
    chk("t3_rdata",    64'(rdata3),  64'hA5A5_A5A5);
    chk("t3_err",      64'(err3),    64'd0);
    tick();
    chk("t3_rvalid_5", 64'(rvalid3), 64'd0);
    chk("t3_rdata_5",  64'(rdata3),  64'd0);
    idle(6);

    wen = 1'b1; waddr = 16'h0000; wdata = 32'h5EED_0001;
    tick();
    wen = 1'b0;
    idle(4);

    // 4: out-of-range and misaligned reads
    ren = 1'b1; raddr = 16'h0040;
    tick();
    ren = 1'b0;
    chk("t4_range_rvalid", 64'(rvalid1), 64'd1);
    chk("t4_range_rdata",  64'(rdata1),  64'd0);
    chk("t4_range_err",    64'(err1),    64'd1);
    tick();
    chk("t4_err_drop", 64'(err1), 64'd0);
    ren = 1'b1; raddr = 16'h0002;
    tick();
    ren = 1'b0;
    chk("t4_align_rvalid", 64'(rvalid1), 64'd1);
    chk("t4_align_rdata",  64'(rdata1),  64'd0);
    chk("t4_align_err",    64'(err1),    64'd1);
    idle(6);

    // 5: second read strobe while busy at latency 4 is dropped
    ren = 1'b1; raddr = 16'h0000;
    tick();
    tick();
    ren = 1'b0;
    chk("t5_err",      64'(err4),    64'd1);
    chk("t5_rvalid_2", 64'(rvalid4), 64'd0);
    tick();
    chk("t5_err_drop", 64'(err4),    64'd0);
    chk("t5_rvalid_3", 64'(rvalid4), 64'd0);
    tick();
    chk("t5_rvalid_4", 64'(rvalid4), 64'd1);
    chk("t5_rdata",    64'(rdata4),  64'h5EED_0001);
    tick();
    chk("t5_rvalid_5", 64'(rvalid4), 64'd0);
    idle(6);

    // 6: reset during a latency-3 read wait
    wen = 1'b1; waddr = 16'h0004; wdata = 32'h0000_0077;
    tick();
    wen = 1'b0;
    chk("t6_reg1_written", 64'(regs3[1*32 +: 32]), 64'h77);
    tick();
    ren = 1'b1; raddr = 16'h0004;
    tick();
    ren = 1'b0;
    rstn = 1'b0;
    #1;
    chk("t6_rst_wack",   64'(wack3),   64'd0);
    chk("t6_rst_rvalid", 64'(rvalid3), 64'd0);
    chk("t6_rst_rdata",  64'(rdata3),  64'd0);
    chk("t6_rst_err",    64'(err3),    64'd0);
    chk("t6_rst_strobe", 64'(strobe3), 64'd0);
    chk("t6_rst_regs",   64'(|regs3),  64'd0);
    idle(2);
    rstn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rvalid3) seen = 1'b1;
    end
    chk("t6_no_rvalid", 64'(seen), 64'd0);
    chk("t6_reg1_reset", 64'(regs3[1*32 +: 32]), 64'd0);
    ren = 1'b1; raddr = 16'h0004;
    tick();
    ren = 1'b0;
    idle(2);
    chk("t6_readback_rvalid", 64'(rvalid3), 64'd1);
    chk("t6_readback_rdata",  64'(rdata3),  64'd0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
